fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one FIFO write port among NUM_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST beats, then moves to the next requester.
- Drives the FIFO w_en/w_data pins directly and watches the FIFO full flag, so w_en is never asserted while the FIFO is full.
- Sits between the producer-side logic and the FIFO instance.

---
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants bursts of up to MAX_BURST beats and never writes while the FIFO is full.
//
// state   | meaning
// S_IDLE  | no owner; pick next requester starting at rr_ptr
// S_BURST | owner holds the write port until release, burst limit, or reset
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic                          busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic [OW-1:0] pick;
  logic          found;
  logic [OW-1:0] owner_inc;
  logic          in_burst;
  logic          accept;
  logic          last_beat;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  assign owner_inc = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign in_burst  = (state_q == S_BURST) && !rst;
  assign accept    = in_burst && req[owner_q] && !fifo_full;
  assign last_beat = (beat_cnt_q == BW'(MAX_BURST - 1));

  always_comb begin
    gnt         = '0;
    ack         = '0;
    busy        = in_burst;
    fifo_w_en   = accept;
    fifo_w_data = '0;
    if (in_burst) gnt[owner_q] = 1'b1;
    if (accept) begin
      ack[owner_q] = 1'b1;
      fifo_w_data  = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (rst) begin
      state_d    = S_IDLE;
      owner_d    = '0;
      rr_ptr_d   = '0;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            owner_d    = pick;
            beat_cnt_d = '0;
            state_d    = S_BURST;
          end
        end
        S_BURST: begin
          if (!req[owner_q]) begin
            state_d  = S_IDLE;
            rr_ptr_d = owner_inc;
          end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (last_beat) begin
              state_d  = S_IDLE;
              rr_ptr_d = owner_inc;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    owner_q    <= owner_d;
    rr_ptr_q   <= rr_ptr_d;
    beat_cnt_q <= beat_cnt_d;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: behavioural reference model,
// directed and random stimulus, and a depth-8 FIFO streaming scenario.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  gnt, ack;
  logic          fifo_full;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_w_data;
  logic          busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: arbitration described as plain integers.
  bit m_bursting = 0;
  int m_owner    = 0;
  int m_rr       = 0;
  int m_beats    = 0;

  // Values sampled just before the most recent clock edge.
  logic [N-1:0]  obs_gnt, obs_ack;
  logic          obs_wen;
  logic [DW-1:0] obs_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                      input logic f, input logic rs);
    logic [N-1:0]  e_gnt, e_ack;
    logic          e_wen, e_busy;
    logic [DW-1:0] e_data;
    bit            acc;
    req = r; req_data = d; fifo_full = f; rst = rs;
    #1;
    e_gnt = '0; e_ack = '0; e_wen = 0; e_busy = 0; e_data = '0; acc = 0;
    if (!rs && m_bursting) begin
      e_busy = 1;
      e_gnt[m_owner] = 1'b1;
      acc = r[m_owner] && !f;
      if (acc) begin
        e_ack = e_gnt;
        e_wen = 1;
        e_data = d[m_owner*DW +: DW];
      end
    end
    chk("gnt", gnt, e_gnt);
    chk("ack", ack, e_ack);
    chk("w_en", fifo_w_en, e_wen);
    chk("w_data", fifo_w_data, e_data);
    chk("busy", busy, e_busy);
    chk("inv_onehot", {30'd0, $onehot0(ack), $onehot0(gnt)}, 32'd3);
    chk("inv_wen_ack", fifo_w_en, |ack);
    chk("inv_no_full_write", fifo_w_en & fifo_full, 1'b0);
    obs_gnt = gnt; obs_ack = ack; obs_wen = fifo_w_en; obs_wdata = fifo_w_data;
    @(posedge clk);
    if (rs) begin
      m_bursting = 0; m_owner = 0; m_rr = 0; m_beats = 0;
    end else if (!m_bursting) begin
      for (int k = 0; k < N; k++) begin
        if (!m_bursting && r[(m_rr + k) % N]) begin
          m_owner = (m_rr + k) % N;
          m_bursting = 1;
          m_beats = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_bursting = 0;
      m_rr = (m_owner + 1) % N;
    end else if (acc) begin
      m_beats++;
      if (m_beats == MB) begin
        m_bursting = 0;
        m_rr = (m_owner + 1) % N;
      end
    end
    #1;
  endtask

  logic [N*DW-1:0] pdata;
  int              nacked;
  int              nwrites;
  int              seq_n [N];
  int              exp_seq [N];
  logic [DW-1:0]   fq [$];
  logic [DW-1:0]   item;
  int              reads;
  bit              rd;

  initial begin
    req = '0; req_data = '0; fifo_full = 0; rst = 1;

    step('0, '0, 1'b0, 1'b1);
    step(4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("reset_gnt", obs_gnt, 4'b0000);

    // Single requester 1, data counts up from 0x10 per acknowledged beat.
    nacked = 0; nwrites = 0;
    for (int c = 0; c < 10; c++) begin
      pdata = '0;
      pdata[1*DW +: DW] = DW'(8'h10 + nacked);
      step(4'b0010, pdata, 1'b0, 1'b0);
      if (obs_ack[1]) nacked++;
      if (obs_wen) nwrites++;
    end
    chk("single_writes", nwrites, 8);
    chk("single_last_data", obs_wdata, 8'h17);

    // All requesting: rr pointer sits at 2 after producer 1's bursts.
    step(4'b1111, 32'h33221100, 1'b0, 1'b0);
    step(4'b1111, 32'h33221100, 1'b0, 1'b0);
    chk("rr_first_owner", obs_gnt, 4'b0100);
    for (int c = 0; c < 20; c++) step(4'b1111, $urandom, 1'b0, 1'b0);

    // Full stall in the middle of a burst.
    for (int c = 0; c < 3; c++) step(4'b1111, $urandom, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step(4'b1111, $urandom, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step(4'b1111, $urandom, 1'b0, 1'b0);

    // Reset mid-burst, then a fresh arbitration from rr_ptr=0.
    step(4'b1001, $urandom, 1'b0, 1'b0);
    step(4'b1001, $urandom, 1'b0, 1'b1);
    chk("rst_mid_wen", obs_wen, 1'b0);
    step(4'b1001, $urandom, 1'b0, 1'b0);
    step(4'b1001, $urandom, 1'b0, 1'b0);
    chk("post_rst_owner", obs_gnt, 4'b0001);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++)
      step(N'($urandom), $urandom, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) == 0));

    // Streaming into a depth-8 FIFO from producers 0..2, 20 beats each.
    step('0, '0, 1'b0, 1'b1);
    for (int p = 0; p < N; p++) begin seq_n[p] = 0; exp_seq[p] = 0; end
    reads = 0;
    for (int c = 0; c < 4000 && reads < 60; c++) begin
      logic [N-1:0] r;
      r = '0; pdata = '0;
      for (int p = 0; p < 3; p++) begin
        r[p] = (seq_n[p] < 20) && ($urandom_range(0, 4) != 0);
        pdata[p*DW +: DW] = {2'(p), 6'(seq_n[p])};
      end
      rd = (fq.size() > 0) && ($urandom_range(0, 2) == 0);
      step(r, pdata, fq.size() == 8, 1'b0);
      for (int p = 0; p < 3; p++) if (obs_ack[p]) seq_n[p]++;
      if (rd) begin
        item = fq.pop_front();
        chk("stream_order", 32'(item[5:0]), 32'(exp_seq[item[7:6]]));
        exp_seq[item[7:6]]++;
        reads++;
      end
      if (obs_wen) begin
        fq.push_back(obs_wdata);
        chk("no_overflow", (fq.size() <= 8), 1'b1);
      end
    end
    chk("stream_reads", reads, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
